mdr_bus_loader: RTL and testbench
=================================

Name: mdr_bus_loader

Overview:
- Receiving end of the shared 16-bit datapath bus: captures a value into the memory data register (MDR), either from the bus or from memory.
- Loads from the bus complete in one cycle. Loads from memory follow a ready handshake with a bounded wait.
- Exposes the captured word, plus a byte-selected, sign-extended view for LDB-type loads.
- Sits between the bus tri-state drivers and the memory model; its MDR output feeds the MDR bus gate.

Parameters:
- WIDTH, 16, data/bus width in bits; only 16 is supported.
- MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_r before flagging an error; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- bus_in  input  16  resolved value of the shared bus
- ld_mdr  input  1  load request from the control store
- mio_en  input  1  1 = source is memory, 0 = source is the bus
- data_size  input  1  1 = word, 0 = byte
- mar0  input  1  bit 0 of the MAR; selects the byte lane
- mem_rdata  input  16  memory read data
- mem_r  input  1  memory ready; qualifies mem_rdata
- mem_en  output  1  memory read enable, held high while waiting
- mdr_out  output  16  current MDR contents
- mdr_byte_sext  output  16  selected byte of the MDR, sign-extended to 16 bits
- mdr_valid  output  1  one-cycle pulse, high in the cycle after each MDR update
- busy  output  1  high while a memory load is in progress
- timeout_err  output  1  sticky error flag for a memory load that exceeded MEM_TIMEOUT

Behaviour:
- Reset (synchronous, active-high): state = IDLE; mdr_out = 0x0000; mem_en, mdr_valid, busy, timeout_err = 0; wait counter = 0.
- Reset asserted mid-wait aborts the load. mem_en is low from the next edge onward, and the MDR is left at 0.

State machine: IDLE, MEM_WAIT, ERROR.

IDLE:
- ld_mdr=1, mio_en=0: at the next edge the MDR is loaded from the bus.
  - data_size=1: MDR <= bus_in.
  - data_size=0: MDR <= {bus_in[7:0], bus_in[7:0]} (low byte replicated into both lanes).
  - mdr_valid pulses for one cycle; the state stays IDLE.
- ld_mdr=1, mio_en=1: next state is MEM_WAIT and the counter is cleared.
  - mem_en=1 and busy=1 from the following cycle.
  - No capture happens in this cycle.
- mem_r while in IDLE is ignored.

MEM_WAIT:
- mem_en=1 and busy=1 throughout.
- Each cycle with mem_r=0 increments the counter.
- mem_r=1: at that edge MDR <= mem_rdata (the full word regardless of data_size). Next state is IDLE; mem_en and busy drop; mdr_valid pulses for one cycle.
- Minimum memory-load latency: request cycle + 1 cycle in MEM_WAIT, with the value visible 2 cycles after the request edge.
- The counter reaching MEM_TIMEOUT with mem_r still 0 sends the machine to ERROR. A mem_r arriving in the same cycle as the timeout wins: the data is captured and there is no error.
- ld_mdr in MEM_WAIT is ignored (no queueing). Changes to bus_in have no effect.

ERROR:
- timeout_err=1 (sticky); mem_en=0; busy=0; the MDR holds its previous value.
- All ld_mdr requests are ignored.
- Exit is by reset only.

Byte view (combinational from the MDR register and mar0):
- mdr_byte_sext = sign-extension of mar0 ? MDR[15:8] : MDR[7:0].
- Valid in every state.

Other rules:
- mdr_valid never asserts in the same cycle as reset.
- Counter width is ceil(log2(MEM_TIMEOUT+1)) bits; it never wraps.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - constant WORD=1'b1 / BYTE=1'b0 for data_size;
  - the default MEM_TIMEOUT.
- One natural sub-module: byte_sext8, a combinational byte select plus 8-to-16 sign extension driven by mar0. It is reusable by the LDB datapath.
- The FSM, counter and MDR register stay in the top module.

Test Plan:
- Bus word load: reset, then ld_mdr=1, mio_en=0, data_size=1, bus_in=0xBEEF for 1 cycle -> next cycle mdr_out=0xBEEF, mdr_valid=1 for exactly 1 cycle, mem_en stays 0.
- Bus byte load with sign view: data_size=0, bus_in=0x12F0 -> mdr_out=0xF0F0; mar0=0 -> mdr_byte_sext=0xFFF0; mar0=1 -> 0xFFF0; repeat with bus_in=0x0070 -> mdr_out=0x7070, mdr_byte_sext=0x0070.
- Memory load with latency: ld_mdr=1, mio_en=1; hold mem_r=0 for 3 cycles, then mem_r=1 with mem_rdata=0x8001 -> mem_en and busy high for exactly 4 cycles, mdr_out=0x8001, single mdr_valid pulse, mdr_byte_sext = 0x0001 (mar0=0) or 0xFF80 (mar0=1).
- Timeout: MEM_TIMEOUT=4, never assert mem_r -> timeout_err=1 after the counter reaches 4; mem_en=0; MDR unchanged; further ld_mdr (either source) ignored until reset clears the flag.
- Timeout boundary: assert mem_r in the same cycle the counter hits MEM_TIMEOUT -> data captured, timeout_err stays 0, state returns to IDLE.
- Reset mid-wait and ignored requests: in MEM_WAIT, pulse ld_mdr with mio_en=0, bus_in=0x5555 -> no MDR change; then assert reset -> next cycle mem_en=0, busy=0, mdr_out=0x0000; a late mem_r=1 afterwards has no effect.

Source files
------------

// File: rtl/mdr_bus_loader_pkg.sv
// mdr_bus_loader shared types and constants.
// State encoding, data_size codes, default timeout.
package mdr_bus_loader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic WORD = 1'b1;
  localparam logic BYTE = 1'b0;

  localparam int MEM_TIMEOUT_DEF = 15;

  function automatic logic [15:0] sext8(
    input logic [7:0] b
  );
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mdr_bus_loader_if.sv
// Memory read handshake between the MDR loader
// and the memory model.
interface mdr_bus_loader_if #(
  parameter int WIDTH = 16
);
  logic             mem_en;
  logic             mem_r;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_en,
    input  mem_r,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    output mem_r,
    output mem_rdata
  );
endinterface

// File: rtl/mdr_bus_loader_byte_sext8.sv
// Byte lane select plus 8-to-16 sign extension.
// Shared with the LDB datapath.
module byte_sext8
  import mdr_bus_loader_pkg::*;
(
  input  logic [15:0] word,
  input  logic        sel,
  output logic [15:0] y
);

  // pick the lane, then sign-extend it
  always_comb begin
    y = sel ? sext8(word[15:8]) : sext8(word[7:0]);
  end

endmodule

// File: rtl/mdr_bus_loader.sv
// MDR capture from the shared bus or from memory,
// with bounded memory wait and sticky timeout.
module mdr_bus_loader
  import mdr_bus_loader_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  bus_in,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              data_size,
  input  logic              mar0,
  mdr_bus_loader_if.master  mem,
  output logic [WIDTH-1:0]  mdr_out,
  output logic [WIDTH-1:0]  mdr_byte_sext,
  output logic              mdr_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(MEM_TIMEOUT);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] mdr, mdr_n;
  logic             vld_q, vld_n;

  // state, counter, MDR and valid pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mdr   <= '0;
      vld_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mdr   <= mdr_n;
      vld_q <= vld_n;
    end
  end

  // next state, counter and capture decisions
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mdr_n   = mdr;
    vld_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld_mdr && mio_en) begin
          state_n = MEM_WAIT;
          cnt_n   = '0;
        end else if (ld_mdr) begin
          mdr_n = (data_size == WORD) ? bus_in
                : {bus_in[7:0], bus_in[7:0]};
          vld_n = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem.mem_r) begin
          mdr_n   = mem.mem_rdata;
          vld_n   = 1'b1;
          state_n = IDLE;
        end else if (cnt == TMAX) begin
          state_n = ERROR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ERROR: begin
        state_n = ERROR;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    mem.mem_en  = (state == MEM_WAIT);
    busy        = (state == MEM_WAIT);
    timeout_err = (state == ERROR);
    mdr_out     = mdr;
    mdr_valid   = vld_q & ~reset;
  end

  byte_sext8 u_sext (
    .word (mdr),
    .sel  (mar0),
    .y    (mdr_byte_sext)
  );

endmodule

// File: tb/tb_mdr_bus_loader.sv
// Scoreboard bench for mdr_bus_loader.
// Directed loads, latency, timeout, reset abort.
module tb_mdr_bus_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic        ld_mdr, mio_en, data_size, mar0;
  logic [15:0] mdr_out, mdr_byte_sext;
  logic        mdr_valid, busy, timeout_err;

  mdr_bus_loader_if #(.WIDTH(16)) mif ();

  mdr_bus_loader #(
    .WIDTH       (16),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_in        (bus_in),
    .ld_mdr        (ld_mdr),
    .mio_en        (mio_en),
    .data_size     (data_size),
    .mar0          (mar0),
    .mem           (mif.master),
    .mdr_out       (mdr_out),
    .mdr_byte_sext (mdr_byte_sext),
    .mdr_valid     (mdr_valid),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic [15:0] lo;
    logic [15:0] hi;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int bcnt   = 0;

  // monitor: pop expectation on every mdr_valid
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) bcnt++;
    if (mdr_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL valid_unexp got mdr_out=%h want no pulse",
                 mdr_out);
      end else begin
        e = q.pop_front();
        if (mdr_out !== e.w) begin
          errors++;
          $display("FAIL mon_mdr got %h want %h", mdr_out, e.w);
        end
        checks++;
        if (mdr_byte_sext !== (mar0 ? e.hi : e.lo)) begin
          errors++;
          $display("FAIL mon_sext got %h want %h", mdr_byte_sext,
                   mar0 ? e.hi : e.lo);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [15:0] a,
                     input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] lo,
                      input logic [15:0] hi);
    exp_t e;
    e.w  = w;
    e.lo = lo;
    e.hi = hi;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int k;
    reset = 1'b1; ld_mdr = 1'b0; mio_en = 1'b0;
    data_size = 1'b1; mar0 = 1'b0; bus_in = '0;
    mif.mem_r = 1'b0; mif.mem_rdata = '0;
    repeat (2) cyc();
    chk("rst_mdr", mdr_out, 16'h0000);
    chk("rst_memen", 16'(mif.mem_en), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_err", 16'(timeout_err), 16'h0);
    chk("rst_valid", 16'(mdr_valid), 16'h0);
    reset = 1'b0;
    cyc();

    // bus word load
    ld_mdr = 1'b1; mio_en = 1'b0; data_size = 1'b1;
    bus_in = 16'hBEEF;
    push(16'hBEEF, 16'hFFEF, 16'hFFBE);
    cyc();
    ld_mdr = 1'b0;
    chk("word_mdr", mdr_out, 16'hBEEF);
    chk("word_memen", 16'(mif.mem_en), 16'h0);
    cyc(); cyc();

    // bus byte loads
    data_size = 1'b0; bus_in = 16'h12F0; ld_mdr = 1'b1;
    push(16'hF0F0, 16'hFFF0, 16'hFFF0);
    cyc();
    ld_mdr = 1'b0; mar0 = 1'b1;
    chk("byte_mdr", mdr_out, 16'hF0F0);
    chk("byte_sext_hi", mdr_byte_sext, 16'hFFF0);
    cyc();
    mar0 = 1'b0;
    bus_in = 16'h0070; ld_mdr = 1'b1;
    push(16'h7070, 16'h0070, 16'h0070);
    cyc();
    ld_mdr = 1'b0;
    chk("byte2_mdr", mdr_out, 16'h7070);
    chk("byte2_sext_lo", mdr_byte_sext, 16'h0070);
    cyc();

    // memory load, 3 stall cycles
    mar0 = 1'b1; data_size = 1'b1;
    b0 = bcnt;
    mio_en = 1'b1; ld_mdr = 1'b1;
    cyc();
    ld_mdr = 1'b0;
    chk("req_nocapture", mdr_out, 16'h7070);
    for (int i = 0; i < 3; i++) begin
      chk("wait_memen", 16'(mif.mem_en), 16'h1);
      cyc();
    end
    mif.mem_r = 1'b1; mif.mem_rdata = 16'h8001;
    push(16'h8001, 16'h0001, 16'hFF80);
    cyc();
    mif.mem_r = 1'b0;
    chk("mem_mdr", mdr_out, 16'h8001);
    chk("mem_memen_drop", 16'(mif.mem_en), 16'h0);
    cyc();
    chk("mem_busy_cycles", 16'(bcnt - b0), 16'd4);
    mar0 = 1'b0;

    // mem_r on the timeout cycle wins
    ld_mdr = 1'b1; mio_en = 1'b1;
    cyc();
    ld_mdr = 1'b0;
    repeat (4) cyc();
    mif.mem_r = 1'b1; mif.mem_rdata = 16'h1234;
    push(16'h1234, 16'h0034, 16'h0012);
    cyc();
    mif.mem_r = 1'b0;
    chk("bnd_mdr", mdr_out, 16'h1234);
    chk("bnd_err", 16'(timeout_err), 16'h0);
    chk("bnd_busy", 16'(busy), 16'h0);
    cyc();

    // ignored bus load in MEM_WAIT, then reset abort
    ld_mdr = 1'b1; mio_en = 1'b1;
    cyc();
    mio_en = 1'b0; bus_in = 16'h5555;
    cyc();
    ld_mdr = 1'b0;
    chk("wait_ignore_mdr", mdr_out, 16'h1234);
    chk("wait_ignore_busy", 16'(busy), 16'h1);
    reset = 1'b1;
    cyc();
    chk("abort_memen", 16'(mif.mem_en), 16'h0);
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_mdr", mdr_out, 16'h0000);
    reset = 1'b0;
    mif.mem_r = 1'b1; mif.mem_rdata = 16'hABCD;
    cyc();
    mif.mem_r = 1'b0;
    chk("late_memr_mdr", mdr_out, 16'h0000);
    cyc();

    // timeout with no mem_r
    ld_mdr = 1'b1; mio_en = 1'b0; data_size = 1'b1;
    bus_in = 16'h4321;
    push(16'h4321, 16'h0021, 16'h0043);
    cyc();
    ld_mdr = 1'b0;
    cyc();
    ld_mdr = 1'b1; mio_en = 1'b1;
    cyc();
    ld_mdr = 1'b0;
    k = 0;
    while (k < 20 && timeout_err !== 1'b1) begin
      cyc();
      k++;
    end
    chk("to_cycles", 16'(k), 16'd5);
    chk("to_err", 16'(timeout_err), 16'h1);
    chk("to_memen", 16'(mif.mem_en), 16'h0);
    chk("to_busy", 16'(busy), 16'h0);
    chk("to_mdr", mdr_out, 16'h4321);
    ld_mdr = 1'b1; mio_en = 1'b0; bus_in = 16'h9999;
    cyc();
    mio_en = 1'b1;
    cyc();
    ld_mdr = 1'b0; mif.mem_r = 1'b1; mif.mem_rdata = 16'hFFFF;
    cyc();
    mif.mem_r = 1'b0;
    chk("err_hold_mdr", mdr_out, 16'h4321);
    chk("err_sticky", 16'(timeout_err), 16'h1);
    chk("err_busy", 16'(busy), 16'h0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("err_clr", 16'(timeout_err), 16'h0);
    chk("err_clr_mdr", mdr_out, 16'h0000);
    cyc(); cyc();
    chk("sb_empty", 16'(q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
